// File: rtl/sc_onehot_arbiter.sv
// Round-robin arbiter feeding a shared one-hot validation register.
// Each grant is checked for exactly one set bit, then acked or nacked.
module sc_onehot_arbiter #(
    parameter int DATAWIDTH = 4,
    parameter int NUM_REQ   = 4
) (
    input  logic                         SC_CLOCK,
    input  logic                         SC_RESET_InHigh,
    input  logic [NUM_REQ-1:0]           req_in,
    input  logic [NUM_REQ*DATAWIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]           ack_out,
    output logic [NUM_REQ-1:0]           nack_out,
    output logic [DATAWIDTH-1:0]         data_out,
    output logic                         load_out,
    output logic [1:0]                   owner_out,
    output logic                         busy_out,
    output logic [7:0]                   err_count_out
);

    localparam int CW = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        LOAD,
        REJECT
    } state_t;

    state_t               state;
    logic [1:0]           ptr;
    logic [DATAWIDTH-1:0] hold_reg;

    logic                 grant_vld;
    logic [1:0]           grant_idx;
    logic [1:0]           scan;
    logic [CW-1:0]        pop;
    logic [NUM_REQ-1:0]   owner_oh;

    // First requester at or after ptr, wrapping modulo 4
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr;
        scan      = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = ptr + 2'(i);
            if (!grant_vld && req_in[scan]) begin
                grant_vld = 1'b1;
                grant_idx = scan;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATAWIDTH; i++) begin
            pop = pop + {{(CW-1){1'b0}}, hold_reg[i]};
        end
    end

    assign owner_oh = NUM_REQ'(1) << owner_out;

    always_ff @(posedge SC_CLOCK) begin
        if (SC_RESET_InHigh) begin
            state         <= IDLE;
            ptr           <= '0;
            hold_reg      <= '0;
            data_out      <= '0;
            load_out      <= 1'b0;
            ack_out       <= '0;
            nack_out      <= '0;
            owner_out     <= '0;
            busy_out      <= 1'b0;
            err_count_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ack_out  <= '0;
                    nack_out <= '0;
                    load_out <= 1'b0;
                    if (grant_vld) begin
                        hold_reg  <= data_in[grant_idx*DATAWIDTH +: DATAWIDTH];
                        owner_out <= grant_idx;
                        busy_out  <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (pop == CW'(1)) begin
                        data_out <= hold_reg;
                        load_out <= 1'b1;
                        ack_out  <= owner_oh;
                        state    <= LOAD;
                    end else begin
                        nack_out <= owner_oh;
                        if (err_count_out != 8'hFF) begin
                            err_count_out <= err_count_out + 8'd1;
                        end
                        state <= REJECT;
                    end
                end
                LOAD, REJECT: begin
                    ack_out  <= '0;
                    nack_out <= '0;
                    load_out <= 1'b0;
                    busy_out <= 1'b0;
                    ptr      <= owner_out + 2'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_onehot_arbiter.sv
// Directed bench for sc_onehot_arbiter.
// Expected responses are queued at drive time and popped on ack/nack.
module tb_sc_onehot_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_in;
    logic [15:0] data_in;
    logic [3:0]  ack_out;
    logic [3:0]  nack_out;
    logic [3:0]  data_out;
    logic        load_out;
    logic [1:0]  owner_out;
    logic        busy_out;
    logic [7:0]  err_count_out;

    sc_onehot_arbiter #(.DATAWIDTH(4), .NUM_REQ(4)) dut (
        .SC_CLOCK        (clk),
        .SC_RESET_InHigh (rst),
        .req_in          (req_in),
        .data_in         (data_in),
        .ack_out         (ack_out),
        .nack_out        (nack_out),
        .data_out        (data_out),
        .load_out        (load_out),
        .owner_out       (owner_out),
        .busy_out        (busy_out),
        .err_count_out   (err_count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] owner;
        logic [3:0] data;
        bit         ok;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [3:0] oh;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_err;
    logic [3:0] exp_data;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(string tag);
        check({tag, "_data"}, 32'(data_out), 0);
        check({tag, "_load"}, 32'(load_out), 0);
        check({tag, "_ack"}, 32'(ack_out), 0);
        check({tag, "_nack"}, 32'(nack_out), 0);
        check({tag, "_owner"}, 32'(owner_out), 0);
        check({tag, "_busy"}, 32'(busy_out), 0);
        check({tag, "_err"}, 32'(err_count_out), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("resp_excl",
                  32'($onehot0(ack_out | nack_out)
                      && !(|ack_out && |nack_out)), 1);
            if (|(ack_out | nack_out)) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp",
                          32'(ack_out | nack_out), 0);
                end else begin
                    e  = sb.pop_front();
                    oh = 4'b0001 << e.owner;
                    check("resp_owner", 32'(owner_out), 32'(e.owner));
                    check("resp_ack", 32'(ack_out), e.ok ? 32'(oh) : 0);
                    check("resp_nack", 32'(nack_out), e.ok ? 0 : 32'(oh));
                    check("resp_load", 32'(load_out), 32'(e.ok));
                    check("resp_busy", 32'(busy_out), 1);
                    if (e.ok) begin
                        check("resp_data", 32'(data_out), 32'(e.data));
                    end
                end
            end
        end
    end

    task automatic do_req(int k, logic [3:0] v);
        exp_t x;
        int   lat;
        x.owner = 2'(k);
        x.data  = v;
        x.ok    = ($countones(v) == 1);
        @(negedge clk);
        req_in[k]          = 1'b1;
        data_in[k*4 +: 4]  = v;
        sb.push_back(x);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(ack_out[k] | nack_out[k]) && lat < 20);
        check("latency", 32'(lat), 2);
        req_in[k] = 1'b0;
        if (x.ok) exp_data = v;
        else if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        @(negedge clk);
        check("busy_idle", 32'(busy_out), 0);
        check("data_hold", 32'(data_out), 32'(exp_data));
        check("err_count", 32'(err_count_out), 32'(exp_err));
    endtask

    initial begin
        int   acks;
        int   last;
        int   cyc;
        exp_t x;
        rst      = 1'b1;
        req_in   = '0;
        data_in  = '0;
        exp_err  = '0;
        exp_data = '0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        do_req(0, 4'b0100);
        check("owner_acc", 32'(owner_out), 0);
        do_req(2, 4'b0110);
        do_req(2, 4'b0000);
        do_req(1, 4'b1111);
        check("owner_rej", 32'(owner_out), 1);

        rst = 1'b1;
        @(negedge clk);
        check_reset("rst2");
        rst      = 1'b0;
        exp_err  = '0;
        exp_data = '0;

        data_in = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            x.owner = 2'(i % 4);
            x.ok    = 1'b1;
            x.data  = 4'b0001 << (i % 4);
            sb.push_back(x);
        end
        req_in = 4'hF;
        acks = 0;
        last = -1;
        cyc  = 0;
        while (acks < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (|ack_out) begin
                if (last >= 0) check("ack_gap", 32'(cyc - last), 3);
                last = cyc;
                acks++;
                if (acks == 5) req_in = '0;
            end
        end
        check("rr_acks", 32'(acks), 5);
        exp_data = 4'b0001;
        @(negedge clk);
        check("rr_data", 32'(data_out), 32'(exp_data));

        x.owner = 2'd3;
        x.data  = 4'b0010;
        x.ok    = 1'b1;
        @(negedge clk);
        req_in[3]      = 1'b1;
        data_in[15:12] = 4'b0010;
        sb.push_back(x);
        @(negedge clk);
        check("wd_busy", 32'(busy_out), 1);
        req_in[3]      = 1'b0;
        data_in[15:12] = 4'b1111;
        cyc = 1;
        while (!ack_out[3] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("wd_latency", 32'(cyc), 2);
        exp_data = 4'b0010;
        @(negedge clk);
        check("wd_data", 32'(data_out), 32'(exp_data));

        for (int i = 0; i < 260; i++) do_req(0, 4'b0011);
        check("sat_err", 32'(err_count_out), 255);

        do_req(1, 4'b0100);
        @(negedge clk);
        req_in[2]     = 1'b1;
        data_in[11:8] = 4'b0001;
        @(negedge clk);
        check("mid_busy", 32'(busy_out), 1);
        rst    = 1'b1;
        req_in = '0;
        @(negedge clk);
        check_reset("mid_rst");
        rst      = 1'b0;
        exp_err  = '0;
        exp_data = '0;
        @(negedge clk);
        check("post_rst_resp", 32'(ack_out | nack_out), 0);
        check("post_rst_busy", 32'(busy_out), 0);

        x.ok    = 1'b1;
        x.owner = 2'd1;
        x.data  = 4'b0100;
        sb.push_back(x);
        x.owner = 2'd3;
        x.data  = 4'b1000;
        sb.push_back(x);
        data_in[7:4]   = 4'b0100;
        data_in[15:12] = 4'b1000;
        req_in = 4'b1010;
        acks = 0;
        cyc  = 0;
        while (acks < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack_out[1]) req_in[1] = 1'b0;
            if (ack_out[3]) req_in[3] = 1'b0;
            if (|ack_out) acks++;
        end
        check("ptr_acks", 32'(acks), 2);
        @(negedge clk);
        check("ptr_data", 32'(data_out), 32'(4'b1000));
        check("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
